// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: data-priority access for a fetch port and a data port,
// with bounded fetch starvation, a per-transaction timeout and misaligned-fetch rejection.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  output logic        ierr,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [3:0]  dbyte_en,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        derr,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  output logic [3:0]  ram_byte_en,
  input  logic [31:0] ram_load,
  input  logic        ram_ready
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic          owner_data;
  logic [SW-1:0] starve_cnt;
  logic [7:0]    tmo_cnt;
  logic          d_req;
  logic          d_grant;
  logic          bus_done;

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  assign d_req    = dren | dwen;
  assign d_grant  = d_req && !(iren && (starve_cnt == SW'(STARVE_MAX)));
  assign bus_done = ram_ready || (tmo_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk) begin
    // NOTE: the RAM-facing registers are reset too, so the bus goes quiet on
    // the reset edge and an abandoned transaction leaves nothing behind.
    if (rst) begin
      state       <= IDLE;
      owner_data  <= 1'b0;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      ram_ren     <= 1'b0;
      ram_wen     <= 1'b0;
      ram_addr    <= '0;
      ram_store   <= '0;
      ram_byte_en <= '0;
      ihit        <= 1'b0;
      ierr        <= 1'b0;
      dhit        <= 1'b0;
      derr        <= 1'b0;
      iload       <= '0;
      dload       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge state and the defaults here are simply overridden.
      ihit <= 1'b0;
      ierr <= 1'b0;
      dhit <= 1'b0;
      derr <= 1'b0;

      case (state)
        IDLE: begin
          if (!iren) starve_cnt <= '0;
          if (d_grant) begin
            if (iren) starve_cnt <= starve_cnt + SW'(1);
            owner_data  <= 1'b1;
            ram_addr    <= daddr;
            ram_wen     <= dwen;
            ram_ren     <= ~dwen;
            ram_store   <= dwen ? dstore : '0;
            ram_byte_en <= dwen ? dbyte_en : 4'hF;
            tmo_cnt     <= '0;
            state       <= BUSY;
          end else if (iren) begin
            starve_cnt <= '0;
            owner_data <= 1'b0;
            if (iaddr[1:0] != 2'b00) begin
              // Rejected without touching the RAM.
              ierr  <= 1'b1;
              iload <= '0;
              state <= RESP;
            end else begin
              ram_addr    <= iaddr;
              ram_ren     <= 1'b1;
              ram_store   <= '0;
              ram_byte_en <= 4'hF;
              tmo_cnt     <= '0;
              state       <= BUSY;
            end
          end
        end

        BUSY: begin
          if (bus_done) begin
            // ram_ready wins over a timeout landing in the same cycle.
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            state   <= RESP;
            if (owner_data) begin
              dhit  <= ram_ready;
              derr  <= ~ram_ready;
              dload <= (ram_ready && !ram_wen) ? ram_load : '0;
            end else begin
              ihit  <= ram_ready;
              ierr  <= ~ram_ready;
              iload <= ram_ready ? ram_load : '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random single-port
// transactions, checked against a transaction-level model and a reference memory.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore;
  logic [3:0]  dbyte_en;
  logic [31:0] iload, dload;
  logic        ihit, ierr, dhit, derr;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_load  = '0;
  logic        ram_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .iren(iren), .iaddr(iaddr), .iload(iload), .ihit(ihit), .ierr(ierr),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dbyte_en(dbyte_en),
    .dload(dload), .dhit(dhit), .derr(derr),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_byte_en(ram_byte_en), .ram_load(ram_load), .ram_ready(ram_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RAM contents as seen by the DUT, and the contents the requesters expect.
  logic [31:0] ram_mem [bit [29:0]];
  logic [31:0] ref_mem [bit [29:0]];

  function automatic logic [31:0] init_val(input bit [29:0] w);
    return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ram_rd(input bit [29:0] w);
    return ram_mem.exists(w) ? ram_mem[w] : init_val(w);
  endfunction

  function automatic logic [31:0] ref_rd(input bit [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // RAM responder: ready after ram_wait strobed cycles; random noise on ready while idle.
  int ram_wait = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (ram_ren || ram_wen) begin
      if (busy_cnt == ram_wait) begin
        ram_ready = 1'b1;
        if (ram_wen) begin
          ram_mem[ram_addr[31:2]] = merge(ram_rd(ram_addr[31:2]), ram_store, ram_byte_en);
          ram_load = $urandom;
        end else begin
          ram_load = ram_rd(ram_addr[31:2]);
        end
      end else begin
        ram_ready = 1'b0;
        ram_load  = $urandom;
      end
      busy_cnt++;
    end else begin
      busy_cnt  = 0;
      ram_ready = 1'($urandom_range(0, 1));
      ram_load  = $urandom;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_bits"}, {26'b0, ram_ren, ram_wen, ihit, ierr, dhit, derr}, '0);
    check({tag, "_ram_addr"}, ram_addr, '0);
    check({tag, "_ram_store"}, ram_store, '0);
    check({tag, "_ram_byte_en"}, 32'(ram_byte_en), '0);
    check({tag, "_iload"}, iload, '0);
    check({tag, "_dload"}, dload, '0);
  endtask

  // One single-port transaction, expectations derived from the timing rules.
  task automatic run_txn(input bit is_d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int w);
    int k, exp_k, busy, ren_n, wen_n;
    bit exp_err, done, mis, is_wr;
    logic [31:0] exp_load;
    logic [3:0]  exp_be;
    k = 0; ren_n = 0; wen_n = 0; done = 1'b0;
    is_wr = is_d && wr;
    mis   = !is_d && (addr[1:0] != 2'b00);
    if (mis) begin
      exp_k = 1; exp_err = 1'b1;
    end else if (w <= TIMEOUT) begin
      exp_k = 2 + w; exp_err = 1'b0;
    end else begin
      exp_k = TIMEOUT + 2; exp_err = 1'b1;
    end
    busy     = mis ? 0 : exp_k - 1;
    exp_load = (exp_err || is_wr) ? '0 : ref_rd(addr[31:2]);
    exp_be   = is_wr ? be : 4'hF;
    if (is_wr && !exp_err) ref_mem[addr[31:2]] = merge(ref_rd(addr[31:2]), wdata, be);

    ram_wait = w;
    if (is_d) begin
      dwen = wr;
      dren = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      daddr = addr; dstore = wdata; dbyte_en = be;
    end else begin
      iren = 1'b1; iaddr = addr;
    end

    while (!done && k < 64) begin
      @(negedge clk);
      k++;
      if (!mis && (k == 1 || k == busy)) begin
        check("ram_addr", ram_addr, addr);
        check("ram_byte_en", 32'(ram_byte_en), 32'(exp_be));
        if (is_wr) check("ram_store", ram_store, wdata);
      end
      if (k == 1) begin
        // Inputs change after grant; the transaction must not follow them.
        iaddr = $urandom; daddr = $urandom; dstore = $urandom; dbyte_en = 4'($urandom);
      end
      ren_n += int'(ram_ren);
      wen_n += int'(ram_wen);
      done = is_d ? (dhit | derr) : (ihit | ierr);
    end

    check("latency", k, exp_k);
    check("err_flag", 32'(is_d ? derr : ierr), 32'(exp_err));
    check("load", is_d ? dload : iload, exp_load);
    check("rd_strobe_cycles", ren_n, is_wr ? 0 : busy);
    check("wr_strobe_cycles", wen_n, is_wr ? busy : 0);
    check("other_port_quiet", 32'(is_d ? (ihit | ierr) : (dhit | derr)), '0);

    iren = 1'b0; dren = 1'b0; dwen = 1'b0;
    @(negedge clk);
    check("pulse_width", 32'(ihit | ierr | dhit | derr), '0);
    check("load_hold", is_d ? dload : iload, exp_load);
    check("strobes_idle", 32'(ram_ren | ram_wen), '0);
  endtask

  // Both ports held continuously: fetch must get every (STARVE_MAX+1)-th grant.
  task automatic contention(input logic [31:0] fa);
    string exp_order;
    byte   got;
    int    n, cyc, run, max_run;
    exp_order = "DDDDIDDDDI";
    n = 0; cyc = 0; run = 0; max_run = 0;
    ram_wait = 1;
    iren = 1'b1; iaddr = fa;
    dren = 1'b1; dwen = 1'b0; daddr = 32'h80;
    while (n < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dhit || ihit || ierr) begin
        got = dhit ? "D" : "I";
        check("grant_order", 32'(got), 32'(exp_order[n]));
        if (fa[1:0] == 2'b00 && ihit) check("contention_iload", iload, ref_rd(fa[31:2]));
        if (fa[1:0] != 2'b00 && !dhit) check("contention_ierr", 32'(ierr), 32'd1);
        run = dhit ? run + 1 : 0;
        if (run > max_run) max_run = run;
        n++;
      end
    end
    check("contention_count", n, 10);
    check("starve_max_run", max_run, STARVE_MAX);
    iren = 1'b0; dren = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          r_is_d, r_wr;
    int          r_w;
    logic [31:0] r_a;
    bit          seen;

    rst = 1'b1; iren = 1'b0; dren = 1'b0; dwen = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; dbyte_en = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, ready after 2 BUSY cycles.
    ram_mem[30'h40] = 32'hDEAD_BEEF;
    ref_mem[30'h40] = 32'hDEAD_BEEF;
    run_txn(1'b0, 1'b0, 32'h100, '0, '0, 2);

    // Data write with partial byte enables, then read it back.
    run_txn(1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'b0011, 0);
    run_txn(1'b1, 1'b0, 32'h200, '0, '0, 1);

    contention(32'h40);
    contention(32'h42);

    // Timeout with ready never arriving, then a normal transaction.
    run_txn(1'b1, 1'b0, 32'h240, '0, '0, TIMEOUT + 50);
    run_txn(1'b1, 1'b0, 32'h240, '0, '0, 0);

    run_txn(1'b0, 1'b0, 32'h102, '0, '0, 0);

    // Reset in the second BUSY cycle.
    ram_wait = 5;
    dren = 1'b1; dwen = 1'b0; daddr = 32'h300;
    @(negedge clk);
    check("rst_pre_busy", 32'(ram_ren), 32'd1);
    @(negedge clk);
    rst = 1'b1; dren = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= ihit | ierr | dhit | derr | ram_ren | ram_wen;
    end
    check("rst_no_hit", 32'(seen), '0);
    run_txn(1'b1, 1'b0, 32'h300, '0, '0, 3);

    for (int t = 0; t < 30; t++) begin
      r_is_d = ($urandom_range(0, 2) != 0);
      r_wr   = 1'($urandom_range(0, 1));
      r_a    = 32'($urandom_range(0, 15)) << 2;
      if (r_is_d) r_a[1:0] = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 5) == 0) r_a[1:0] = 2'($urandom_range(1, 3));
      r_w = ($urandom_range(0, 7) == 0) ? TIMEOUT + 3 : $urandom_range(0, 4);
      run_txn(r_is_d, r_wr, r_a, $urandom, 4'($urandom), r_w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
